// File: rtl/lutram_arb_pkg.sv
// Shared types and constants for the LUTRAM arbiter: FSM encoding, stats width, clog2 helper.
package lutram_arb_pkg;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2
  } state_e;

  localparam int unsigned StatsWidth = 16;

  // Minimum of 1 so a 1-requester index still has a legal width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a rotating pointer.
module rr_arbiter
  import lutram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IdxW   = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IdxW-1:0]    o_idx,
  output logic               o_any
);

  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    if (i_en) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_j = IdxW'((32'(r_ptr) + k) % NUM_REQ);
        if (!o_any && i_valid[w_j]) begin
          o_any      = 1'b1;
          o_idx      = w_j;
          o_grant[w_j] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (o_any) begin
      r_ptr <= (32'(o_idx) == NUM_REQ - 1) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/lutram_arbiter.sv
// Shares one single-port async-read LUTRAM between requesters after a mandatory clear pass.
// Optional per-requester grant / contention counters under LUTRAM_ARB_STATS_EN.
module lutram_arbiter
  import lutram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned D_WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ-1:0]           i_req_we,
  input  logic [NUM_REQ*A_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*D_WIDTH-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [NUM_REQ-1:0]           o_rsp_valid,
  output logic [D_WIDTH-1:0]           o_rsp_rdata,
  output logic                         o_init_done,
  output logic                         o_ram_we,
  output logic [A_WIDTH-1:0]           o_ram_a,
  output logic [D_WIDTH-1:0]           o_ram_d,
`ifdef LUTRAM_ARB_STATS_EN
  output logic [NUM_REQ*StatsWidth-1:0] o_stat_grants,
  output logic [StatsWidth-1:0]         o_stat_stalls,
`endif
  input  logic [D_WIDTH-1:0]           i_ram_o
);

  localparam int unsigned IdxW = clog2(NUM_REQ);

  state_e               r_state, w_state_next;
  logic [A_WIDTH-1:0]   r_cnt;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [D_WIDTH-1:0]   r_rsp_rdata;
  logic                 w_run, w_any, w_sel_we, w_rd_grant;
  logic [NUM_REQ-1:0]   w_grant;
  logic [IdxW-1:0]      w_idx;
  logic [A_WIDTH-1:0]   w_sel_addr;
  logic [D_WIDTH-1:0]   w_sel_wdata;

  assign w_run = (r_state == StRun);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run),
    .i_valid(i_req_valid),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  assign w_sel_we    = i_req_we[w_idx];
  assign w_sel_addr  = i_req_addr[32'(w_idx)*A_WIDTH +: A_WIDTH];
  assign w_sel_wdata = i_req_wdata[32'(w_idx)*D_WIDTH +: D_WIDTH];
  assign w_rd_grant  = w_any && !w_sel_we;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StInit:  w_state_next = StClear;
      StClear: if (r_cnt == '1) w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      // Counter wraps to 0 on the final clear write; it is unused once in RUN.
      if (r_state == StInit)       r_cnt <= '0;
      else if (r_state == StClear) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    o_ram_we = 1'b0;
    o_ram_a  = '0;
    o_ram_d  = '0;
    if (r_state == StClear) begin
      o_ram_we = 1'b1;
      o_ram_a  = r_cnt;
    end else if (w_any) begin
      o_ram_we = w_sel_we;
      o_ram_a  = w_sel_addr;
      if (w_sel_we) o_ram_d = w_sel_wdata;
    end
  end

  // Async-read RAM output is captured on the read-grant edge: 1-cycle response latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd_grant ? w_grant : '0;
      if (w_rd_grant) r_rsp_rdata <= i_ram_o;
    end
  end

  assign o_req_ready = w_grant;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_init_done = w_run;

`ifdef LUTRAM_ARB_STATS_EN
  logic [NUM_REQ*StatsWidth-1:0] r_stat_grants;
  logic [StatsWidth-1:0]         r_stat_stalls;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_grants <= '0;
      r_stat_stalls <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && r_stat_grants[i*StatsWidth +: StatsWidth] != '1) begin
          r_stat_grants[i*StatsWidth +: StatsWidth] <=
              r_stat_grants[i*StatsWidth +: StatsWidth] + 1'b1;
        end
      end
      if (w_run && $countones(i_req_valid) > 1 && r_stat_stalls != '1) begin
        r_stat_stalls <= r_stat_stalls + 1'b1;
      end
    end
  end

  assign o_stat_grants = r_stat_grants;
  assign o_stat_stalls = r_stat_stalls;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_lutram_arbiter.sv
// Self-checking bench: behavioural RAM + reference arbiter model, directed and random stimulus.
module tb_lutram_arbiter;

  localparam int NR = 2;
  localparam int AW = 8;
  localparam int DW = 1;
  localparam int Depth = 1 << AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [DW-1:0]     rsp_rdata, ram_d, ram_o;
  logic [AW-1:0]     ram_a;
  logic              ram_we, init_done;
`ifdef LUTRAM_ARB_STATS_EN
  logic [NR*16-1:0]  stat_grants;
  logic [15:0]       stat_stalls;
`endif

  always #5 clk = ~clk;

  lutram_arbiter #(.NUM_REQ(NR), .A_WIDTH(AW), .D_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_rdata  (rsp_rdata),
    .o_init_done  (init_done),
    .o_ram_we     (ram_we),
    .o_ram_a      (ram_a),
    .o_ram_d      (ram_d),
`ifdef LUTRAM_ARB_STATS_EN
    .o_stat_grants(stat_grants),
    .o_stat_stalls(stat_stalls),
`endif
    .i_ram_o      (ram_o)
  );

  // Behavioural RAM256X1S: async read, write on clk edge.
  logic [DW-1:0] ram_mem [Depth];
  always @(posedge clk) if (ram_we) ram_mem[ram_a] <= ram_d;
  assign ram_o = ram_mem[ram_a];

  // Reference model state.
  logic [DW-1:0] ref_mem [Depth];
  int            ref_ptr;
  logic [NR-1:0] exp_rv;
  logic [DW-1:0] exp_rd;
  int            last_g;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int model_grant(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
    ref_ptr = 0;
    exp_rv  = '0;
    exp_rd  = '0;
  endtask

  // Release reset at a negedge with requests pending and count edges to init_done.
  task automatic wait_init();
    int   cycles;
    logic ready_seen;
    cycles     = 0;
    ready_seen = 1'b0;
    req_valid  = '1;
    req_we     = '0;
    rst        = 1'b0;
    while (cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (init_done) break;
      if (req_ready != '0) ready_seen = 1'b1;
    end
    req_valid = '0;
    check("init_cycles", cycles, Depth + 1);
    check("ready_during_clear", ready_seen, 1'b0);
    model_reset();
  endtask

  task automatic run_cycle(input logic [NR-1:0] v, input logic [NR-1:0] we,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int            g;
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    @(negedge clk);
    check("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv != '0) check("rsp_rdata", rsp_rdata, exp_rd);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    #1;
    g = model_grant(v, ref_ptr);
    last_g = g;
    check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    if (g >= 0) begin
      addr = (g == 0) ? a0 : a1;
      dat  = (g == 0) ? d0 : d1;
      check("ram_a", ram_a, addr);
      check("ram_we", ram_we, we[g]);
      if (we[g]) begin
        ref_mem[addr] = dat;
        exp_rv = '0;
      end else begin
        exp_rv = NR'(1 << g);
        exp_rd = ref_mem[addr];
      end
      ref_ptr = (g + 1) % NR;
    end else begin
      check("ram_we_idle", ram_we, 1'b0);
      exp_rv = '0;
    end
  endtask

  logic [NR-1:0] rv, rwe;
  logic [AW-1:0] ra [NR];
  logic [DW-1:0] rd [NR];

  initial begin
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    last_g = -1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);
    wait_init();

    // Whole RAM reads back 0 after the clear pass.
    for (int a = 0; a < Depth; a++) run_cycle(2'b01, 2'b00, AW'(a), '0, '0, '0);
    run_cycle('0, '0, '0, '0, '0, '0);

    // Read-after-write on consecutive cycles returns the new data.
    run_cycle(2'b01, 2'b01, 8'h5A, '0, 1'b1, '0);
    run_cycle(2'b01, 2'b00, 8'h5A, '0, '0, '0);
    run_cycle('0, '0, '0, '0, '0, '0);

    // Both reading continuously: alternating grants.
    for (int i = 0; i < 6; i++) run_cycle(2'b11, 2'b00, 8'h5A, 8'h10, '0, '0);
    run_cycle('0, '0, '0, '0, '0, '0);

    // Lone requester 1 is granted every cycle.
    for (int i = 0; i < 5; i++) run_cycle(2'b10, 2'b00, '0, AW'(i), '0, '0);
    run_cycle(2'b11, 2'b00, 8'h01, 8'h02, '0, '0);
    run_cycle('0, '0, '0, '0, '0, '0);

    // Alternating pattern via requester 1, read back via requester 0.
    for (int a = 0; a < Depth; a++) begin
      logic [AW-1:0] av;
      av = AW'(a);
      run_cycle(2'b10, 2'b10, '0, av, '0, av[0]);
    end
    for (int a = 0; a < Depth; a++) run_cycle(2'b01, 2'b00, AW'(a), '0, '0, '0);
    run_cycle('0, '0, '0, '0, '0, '0);

    // Random traffic; a request is held stable until it is granted.
    for (int i = 0; i < NR; i++) begin
      rv[i] = $urandom_range(0, 3) != 0; rwe[i] = 1'($urandom);
      ra[i] = AW'($urandom_range(0, 15)); rd[i] = DW'($urandom);
    end
    for (int n = 0; n < 300; n++) begin
      run_cycle(rv, rwe, ra[0], ra[1], rd[0], rd[1]);
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] || last_g == i) begin
          rv[i] = $urandom_range(0, 3) != 0; rwe[i] = 1'($urandom);
          ra[i] = AW'($urandom_range(0, 15)); rd[i] = DW'($urandom);
        end
      end
    end
    run_cycle('0, '0, '0, '0, '0, '0);

    // Mid-stream reset after a read grant drops the pending response and re-clears.
    run_cycle(2'b01, 2'b01, 8'h21, '0, 1'b1, '0);
    run_cycle(2'b01, 2'b00, 8'h21, '0, '0, '0);
    @(negedge clk);
    check("pre_rst_rsp_valid", rsp_valid, exp_rv);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("rst_drop_rsp", rsp_valid, 0);
    check("rst_init_low", init_done, 0);
    check("rst_init_we", ram_we, 0);
    wait_init();
    run_cycle(2'b01, 2'b00, 8'h21, '0, '0, '0);
    run_cycle(2'b01, 2'b00, 8'h5A, '0, '0, '0);
    run_cycle(2'b01, 2'b00, 8'h01, '0, '0, '0);
    run_cycle('0, '0, '0, '0, '0, '0);
    @(negedge clk);
    check("final_rsp_valid", rsp_valid, exp_rv);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
